// File: rtl/shift_issue_stage_if.sv
// Handshake bundle for shift_issue_stage.
// The request side carries in_valid/in_ready with the in_a/in_b operands.
// The result side carries out_valid/out_ready with out_data.
// Optional feature macro: SHIFT_ZERO_FLAG_EN adds out_zero.
interface shift_issue_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SHIFT_ZERO_FLAG_EN
  logic             out_zero;
`endif

  // Producer/consumer view: drives requests and result acceptance
  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    input  out_valid,
    output out_ready,
`ifdef SHIFT_ZERO_FLAG_EN
    input  out_zero,
`endif
    input  out_data
  );

  // Stage view: accepts requests and presents results
  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    output out_valid,
    input  out_ready,
`ifdef SHIFT_ZERO_FLAG_EN
    output out_zero,
`endif
    output out_data
  );
endinterface

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: operand issue / result capture around a combinational Shifter.
// Requests {A, B} queue in a DEPTH-entry FIFO; the head entry drives the Shifter,
// and the Shifter output is captured into a result register with a valid/ready
// handshake. in_ready depends only on registered state, never on out_ready.
// Optional feature macro: SHIFT_ZERO_FLAG_EN (adds the registered out_zero flag).
module shift_issue_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  shift_issue_stage_if.slave bus,
  output logic [WIDTH-1:0]   sh_a_o,
  output logic [WIDTH-1:0]   sh_b_o,
  input  logic [WIDTH-1:0]   sh_o_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] memA_q [DEPTH];
  logic [WIDTH-1:0] memB_q [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
`ifdef SHIFT_ZERO_FLAG_EN
  logic             outZero_q, outZero_d;
`endif

  logic notEmpty;
  logic inReady;
  logic outFree;
  logic push;
  logic pop;

  // Handshake qualifiers; in_ready is held low while reset is asserted
  always_comb begin
    notEmpty = (count_q != '0);
    inReady  = ~rst_i & (count_q != FULL_CNT);
    outFree  = ~outValid_q | bus.out_ready;
    push     = bus.in_valid & inReady;
    pop      = notEmpty & outFree;
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
`ifdef SHIFT_ZERO_FLAG_EN
  assign bus.out_zero  = outZero_q;
`endif

  // Present the FIFO head to the Shifter, forcing zero when the queue is empty
  always_comb begin
    sh_a_o = '0;
    sh_b_o = '0;
    if (notEmpty) begin
      sh_a_o = memA_q[rdPtr_q];
      sh_b_o = memB_q[rdPtr_q];
    end
  end

  // Next-state for pointers, occupancy and the result register
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
`ifdef SHIFT_ZERO_FLAG_EN
    outZero_d  = outZero_q;
`endif
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d    = rdPtr_q + PTR_W'(1);
      outValid_d = 1'b1;
      outData_d  = sh_o_i;
`ifdef SHIFT_ZERO_FLAG_EN
      outZero_d  = (sh_o_i == '0);
`endif
    end else if (bus.out_ready && outValid_q) begin
      outValid_d = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Operand storage; writes are already gated off during reset through push
  always_ff @(posedge clk_i) begin
    if (push) begin
      memA_q[wrPtr_q] <= bus.in_a;
      memB_q[wrPtr_q] <= bus.in_b;
    end
  end

  // Control and result state with synchronous reset discarding all entries
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
`ifdef SHIFT_ZERO_FLAG_EN
      outZero_q  <= 1'b0;
`endif
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
`ifdef SHIFT_ZERO_FLAG_EN
      outZero_q  <= outZero_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with a behavioural Shifter (A << B[3:0]).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Optional feature macro: SHIFT_ZERO_FLAG_EN enables out_zero checks.
module tb_shift_issue_stage;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] shA;
  logic [WIDTH-1:0] shB;
  logic [WIDTH-1:0] shO;

  int total = 0;
  int bad   = 0;

  shift_issue_stage_if #(.WIDTH(WIDTH)) bus ();

  shift_issue_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .sh_a_o (shA),
    .sh_b_o (shB),
    .sh_o_i (shO)
  );

  // Behavioural Shifter model
  assign shO = shA << shB[3:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic ready);
    bus.in_valid  = valid;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);

    // Reset state
    tick();
    checkOutput("rst_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_data", {16'b0, bus.out_data}, 32'h0000);
    checkOutput("rst_sh_a_empty", {16'b0, shA}, 32'h0000);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Single request: 3 << 2 = 0xC
    applyStimulus(1'b1, 16'h0003, 16'h0002, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    checkOutput("single_head_a", {16'b0, shA}, 32'h0003);
    checkOutput("single_head_b", {16'b0, shB}, 32'h0002);
    checkOutput("single_not_yet", {31'b0, bus.out_valid}, 32'd0);
    tick();
    checkOutput("single_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("single_data", {16'b0, bus.out_data}, 32'h000C);
    tick();
    checkOutput("single_drop", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("single_hold", {16'b0, bus.out_data}, 32'h000C);

    // Stream: A=1..4, B=1, results 2,4,6,8 on consecutive cycles
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, WIDTH'(i), 16'h0001, 1'b1);
      tick();
      checkOutput("stream_ready", {31'b0, bus.in_ready}, 32'd1);
      if (i >= 2) begin
        checkOutput("stream_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("stream_data", {16'b0, bus.out_data}, 32'((i - 1) * 2));
      end
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    tick();
    checkOutput("stream_last_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("stream_last_data", {16'b0, bus.out_data}, 32'h0008);
    tick();
    checkOutput("stream_idle", {31'b0, bus.out_valid}, 32'd0);

    // Stall: out_ready=0, push A=5,6,7 (B=1)
    applyStimulus(1'b1, 16'h0005, 16'h0001, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0006, 16'h0001, 1'b0);
    tick();
    checkOutput("stall_first_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("stall_first_data", {16'b0, bus.out_data}, 32'h000A);
    applyStimulus(1'b1, 16'h0007, 16'h0001, 1'b0);
    tick();
    checkOutput("stall_full_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("stall_held_data", {16'b0, bus.out_data}, 32'h000A);
    checkOutput("stall_held_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("stall_head_a", {16'b0, shA}, 32'h0006);

    // Full + pop: in_ready stays low this cycle despite out_ready=1
    applyStimulus(1'b1, 16'h0008, 16'h0001, 1'b1);
    #1;
    checkOutput("fullpop_ready_low", {31'b0, bus.in_ready}, 32'd0);
    tick();
    checkOutput("fullpop_data6", {16'b0, bus.out_data}, 32'h000C);
    checkOutput("fullpop_ready_back", {31'b0, bus.in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    checkOutput("fullpop_data7", {16'b0, bus.out_data}, 32'h000E);
    tick();
    checkOutput("fullpop_data8", {16'b0, bus.out_data}, 32'h0010);
    checkOutput("fullpop_valid8", {31'b0, bus.out_valid}, 32'd1);
    tick();
    checkOutput("fullpop_idle", {31'b0, bus.out_valid}, 32'd0);

    // Reset mid-stream discards queued and held entries
    applyStimulus(1'b1, 16'h0009, 16'h0001, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0003, 16'h0001, 1'b0);
    tick();
    checkOutput("midrst_pre_data", {16'b0, bus.out_data}, 32'h0012);
    rst = 1'b1;
    applyStimulus(1'b1, 16'h0055, 16'h0001, 1'b0);
    #1;
    checkOutput("midrst_ready_low", {31'b0, bus.in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    #1;
    checkOutput("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("midrst_data", {16'b0, bus.out_data}, 32'h0000);
    checkOutput("midrst_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("midrst_empty", {16'b0, shA}, 32'h0000);
    tick();
    checkOutput("midrst_lost", {31'b0, bus.out_valid}, 32'd0);

    // Zero result: 0x8000 << 1 truncates to 0, then 1 << 0 = 1
    applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b1);
    tick();
    applyStimulus(1'b1, 16'h0001, 16'h0000, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    checkOutput("zero_data", {16'b0, bus.out_data}, 32'h0000);
    checkOutput("zero_valid", {31'b0, bus.out_valid}, 32'd1);
`ifdef SHIFT_ZERO_FLAG_EN
    checkOutput("zero_flag_set", {31'b0, bus.out_zero}, 32'd1);
`endif
    tick();
    checkOutput("nonzero_data", {16'b0, bus.out_data}, 32'h0001);
`ifdef SHIFT_ZERO_FLAG_EN
    checkOutput("zero_flag_clr", {31'b0, bus.out_zero}, 32'd0);
`endif
    tick();
    checkOutput("final_idle", {31'b0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
